counter_modn_chain: RTL and testbench

Parametrised, cascadable modulo-N counter: DIGITS digit stages, each counting 0..MOD-1, chained by an internal ripple-enable carry. It generalises the single-digit decade counter (cnt/cout) with up/down direction, count enable, synchronous clear and load, a cascade carry output and a sticky overflow flag. It serves as the timebase and event counter (BCD display, prescalers) in the FPGA designs.

---
 rtl/counter_modn_chain_pkg.sv | 16 +
 rtl/counter_modn_chain_digit.sv | 45 ++++
 rtl/counter_modn_chain.sv | 86 ++++++++
 tb/tb_counter_modn_chain.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_modn_chain_pkg.sv
// Shared types and helpers for the cascadable modulo-N counter.
// Direction encoding and load-value saturation used by every digit stage.
package counter_pkg;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_t;

   // Out-of-range load digits collapse to zero instead of wrapping.
   function automatic int unsigned sat_digit(input int unsigned value,
                                             input int unsigned modulus);
      return (value < modulus) ? value : 0;
   endfunction

endpackage

// File: rtl/counter_modn_chain_digit.sv
// One modulo-MOD digit stage: clear, saturating load, and up/down step with wrap.
// at_max / at_zero feed the ripple-enable chain in the parent.
module counter_digit
   import counter_pkg::*;
#(
   parameter  int MOD = 10,
   localparam int DW  = $clog2(MOD)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          clr,
   input  logic          load,
   input  logic [DW-1:0] load_d,
   input  logic          step,
   input  dir_t          dir,
   output logic [DW-1:0] d,
   output logic          at_max,
   output logic          at_zero
);

   localparam logic [DW-1:0] MAX_VAL = DW'(MOD - 1);

   logic [DW-1:0] r_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_d <= '0;
      end else if (clr) begin
         r_d <= '0;
      end else if (load) begin
         r_d <= DW'(sat_digit(32'(load_d), MOD));
      end else if (step) begin
         if (dir == DIR_UP) begin
            r_d <= (r_d == MAX_VAL) ? '0 : r_d + DW'(1);
         end else begin
            r_d <= (r_d == '0) ? MAX_VAL : r_d - DW'(1);
         end
      end
   end

   assign d       = r_d;
   assign at_max  = (r_d == MAX_VAL);
   assign at_zero = (r_d == '0);

endmodule

// File: rtl/counter_modn_chain.sv
// Cascadable DIGITS x modulo-MOD counter with up/down, clear, load, carry-out and sticky wrap flag.
// Digit i steps only when every lower digit sits at its terminal value for the current direction.
module counter_modn_chain
   import counter_pkg::*;
#(
   parameter  int DIGITS = 2,
   parameter  int MOD    = 10,
   localparam int DW     = $clog2(MOD)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 en,
   input  logic                 dir,
   input  logic                 clr,
   input  logic                 load,
   input  logic [DIGITS*DW-1:0] load_val,
   output logic [DIGITS*DW-1:0] cnt,
   output logic                 cout,
   output logic                 ovf
);

   dir_t              w_dir;
   logic              w_count;
   logic              w_terminal;
   logic [DIGITS-1:0] w_at_max;
   logic [DIGITS-1:0] w_at_zero;
   logic [DIGITS-1:0] w_step;
   logic [DIGITS:0]   w_lo_max;
   logic [DIGITS:0]   w_lo_zero;
   logic              r_ovf;

   assign w_dir   = dir_t'(dir);
   assign w_count = en & ~clr & ~load;

   // w_lo_*[i]: all digits below i are at max / zero; index DIGITS covers the whole chain.
   always_comb begin
      w_lo_max     = '0;
      w_lo_zero    = '0;
      w_lo_max[0]  = 1'b1;
      w_lo_zero[0] = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         w_lo_max[i+1]  = w_lo_max[i]  & w_at_max[i];
         w_lo_zero[i+1] = w_lo_zero[i] & w_at_zero[i];
      end
   end

   always_comb begin
      w_step = '0;
      for (int i = 0; i < DIGITS; i++) begin
         w_step[i] = w_count & ((w_dir == DIR_UP) ? w_lo_max[i] : w_lo_zero[i]);
      end
   end

   assign w_terminal = (w_dir == DIR_UP) ? w_lo_max[DIGITS] : w_lo_zero[DIGITS];
   assign cout       = w_count & w_terminal;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      counter_digit #(
         .MOD (MOD)
      ) u_digit (
         .clk     (clk),
         .rstn    (rstn),
         .clr     (clr),
         .load    (load),
         .load_d  (load_val[g*DW +: DW]),
         .step    (w_step[g]),
         .dir     (w_dir),
         .d       (cnt[g*DW +: DW]),
         .at_max  (w_at_max[g]),
         .at_zero (w_at_zero[g])
      );
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ovf <= 1'b0;
      end else if (clr) begin
         r_ovf <= 1'b0;
      end else if (cout) begin
         r_ovf <= 1'b1;
      end
   end

   assign ovf = r_ovf;

endmodule

// File: tb/tb_counter_modn_chain.sv
// Self-checking bench for counter_modn_chain (DIGITS=2, MOD=10): vector table,
// hand-written corner sequences and random stimulus against an integer reference model.
module tb_counter_modn_chain;

   logic       clk;
   logic       rstn;
   logic       en;
   logic       dir;
   logic       clr;
   logic       load;
   logic [7:0] load_val;
   logic [7:0] cnt;
   logic       cout;
   logic       ovf;

   int vectors;
   int miscompares;

   // Reference model: the count as a plain integer 0..99.
   int   m_val;
   logic m_ovf;

   typedef struct {
      logic       en;
      logic       dir;
      logic       clr;
      logic       load;
      logic [7:0] lv;
      logic [7:0] exp_cnt;
      logic       exp_cout;
      logic       exp_ovf;
   } vec_t;

   vec_t tbl[19];

   counter_modn_chain #(
      .DIGITS (2),
      .MOD    (10)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .en       (en),
      .dir      (dir),
      .clr      (clr),
      .load     (load),
      .load_val (load_val),
      .cnt      (cnt),
      .cout     (cout),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int dec(input logic [7:0] v);
      int hi;
      int lo;
      hi = int'(v[7:4]);
      lo = int'(v[3:0]);
      if (hi > 9) hi = 0;
      if (lo > 9) lo = 0;
      return hi * 10 + lo;
   endfunction

   function automatic logic [7:0] enc(input int v);
      logic [3:0] hi;
      logic [3:0] lo;
      hi = 4'(v / 10);
      lo = 4'(v % 10);
      return {hi, lo};
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Called before the edge: returns the expected carry and advances the model.
   task automatic model_step(input logic e, input logic d, input logic c, input logic l,
                             input logic [7:0] v, output logic m_cout);
      m_cout = e & ~c & ~l & (d ? (m_val == 99) : (m_val == 0));
      if (c) begin
         m_val = 0;
         m_ovf = 1'b0;
      end else if (l) begin
         m_val = dec(v);
      end else if (e) begin
         m_val = d ? (m_val + 1) % 100 : (m_val + 99) % 100;
         if (m_cout) m_ovf = 1'b1;
      end
   endtask

   // Entered and left at a falling edge.
   task automatic drive(input logic e, input logic d, input logic c, input logic l,
                        input logic [7:0] v, output logic a_cout,
                        output logic [7:0] a_cnt, output logic a_ovf);
      en       = e;
      dir      = d;
      clr      = c;
      load     = l;
      load_val = v;
      #1;
      a_cout = cout;
      @(posedge clk);
      #1;
      a_cnt = cnt;
      a_ovf = ovf;
      @(negedge clk);
   endtask

   task automatic cyc_model(input logic e, input logic d, input logic c, input logic l,
                            input logic [7:0] v, input string tag);
      logic       a_cout;
      logic [7:0] a_cnt;
      logic       a_ovf;
      logic       m_cout;
      model_step(e, d, c, l, v, m_cout);
      drive(e, d, c, l, v, a_cout, a_cnt, a_ovf);
      chk({tag, "_cout"}, {7'd0, a_cout}, {7'd0, m_cout});
      chk({tag, "_cnt"},  a_cnt, enc(m_val));
      chk({tag, "_ovf"},  {7'd0, a_ovf}, {7'd0, m_ovf});
   endtask

   initial begin
      logic       a_cout;
      logic [7:0] a_cnt;
      logic       a_ovf;
      logic       m_cout;

      vectors     = 0;
      miscompares = 0;

      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h47, 8'h47, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, 8'h30, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h31, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h30, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h99, 8'h99, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 8'h55, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h47, 8'h00, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 8'h05, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h99, 1'b1, 1'b1};
      tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h98, 1'b0, 1'b1};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1};
      tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
      tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA9, 8'h09, 1'b0, 1'b1};

      rstn     = 1'b0;
      en       = 1'b0;
      dir      = 1'b1;
      clr      = 1'b0;
      load     = 1'b0;
      load_val = 8'h00;
      m_val    = 0;
      m_ovf    = 1'b0;

      #2;
      chk("reset_cnt",  cnt, 8'h00);
      chk("reset_ovf",  {7'd0, ovf}, 8'h00);
      chk("reset_cout", {7'd0, cout}, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;

      // Vector table
      for (int i = 0; i < 19; i++) begin
         model_step(tbl[i].en, tbl[i].dir, tbl[i].clr, tbl[i].load, tbl[i].lv, m_cout);
         drive(tbl[i].en, tbl[i].dir, tbl[i].clr, tbl[i].load, tbl[i].lv, a_cout, a_cnt, a_ovf);
         chk($sformatf("tbl%0d_cout", i), {7'd0, a_cout}, {7'd0, tbl[i].exp_cout});
         chk($sformatf("tbl%0d_cnt", i),  a_cnt, tbl[i].exp_cnt);
         chk($sformatf("tbl%0d_ovf", i),  {7'd0, a_ovf}, {7'd0, tbl[i].exp_ovf});
      end

      // Full up sweep from 00: 01..99 then wrap to 00 with ovf.
      cyc_model(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "sweep_clr");
      for (int k = 0; k < 100; k++) begin
         cyc_model(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, "sweep_up");
      end
      chk("sweep_end_cnt", cnt, 8'h00);
      chk("sweep_end_ovf", {7'd0, ovf}, 8'h01);

      // Down from 00 after clear: 99, 98, 97.
      cyc_model(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "down_clr");
      for (int k = 0; k < 3; k++) begin
         cyc_model(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "down");
      end
      chk("down_end_cnt", cnt, 8'h97);

      // Asynchronous reset between edges at cnt=72 with ovf set.
      cyc_model(1'b0, 1'b1, 1'b0, 1'b1, 8'h72, "arst_load");
      chk("arst_pre_ovf", {7'd0, ovf}, 8'h01);
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      chk("arst_cnt", cnt, 8'h00);
      chk("arst_ovf", {7'd0, ovf}, 8'h00);
      m_val = 0;
      m_ovf = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      cyc_model(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, "arst_resume");
      chk("arst_resume_cnt", cnt, 8'h01);

      // Random stimulus
      for (int k = 0; k < 1500; k++) begin
         logic       e;
         logic       d;
         logic       c;
         logic       l;
         logic [7:0] v;
         e = ($urandom_range(0, 9) < 8);
         d = 1'($urandom_range(0, 1));
         c = ($urandom_range(0, 49) == 0);
         l = ($urandom_range(0, 19) == 0);
         v = 8'($urandom_range(0, 255));
         cyc_model(e, d, c, l, v, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
